// File: rtl/pattern_gen_multimode.sv
// Multi-mode video test-pattern generator: five patterns selected per frame, registered RGB,
// frame counter and a data-enable aligned with the colour outputs.
module pattern_gen_multimode #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned BORDER     = 20,
  parameter int unsigned BOX_HALF   = 10,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned BOX_SIZE   = 64,
  parameter int unsigned SPEED      = 4
) (
  input  logic               pixelClk,
  input  logic               reset,
  input  logic               vs,
  input  logic               de,
  input  logic [COORD_W-1:0] pixelsX,
  input  logic [COORD_W-1:0] pixelsY,
  input  logic [2:0]         mode,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               deOut,
  output logic [7:0]         frameCount,
  output logic [2:0]         activeMode
);

  localparam int unsigned HalfX   = H_ACTIVE / 2;
  localparam int unsigned HalfY   = V_ACTIVE / 2;
  localparam int unsigned BarW    = H_ACTIVE / 8;
  localparam int unsigned DarkInt = (32'h20 << COLOR_W) >> 8;

  localparam logic [COLOR_W-1:0] Full   = '1;
  localparam logic [COLOR_W-1:0] Dark   = COLOR_W'(DarkInt);
  localparam logic [COORD_W:0]   LimX   = (COORD_W + 1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0]   LimY   = (COORD_W + 1)'(V_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0]   SpeedW = (COORD_W + 1)'(SPEED);

  // {r,g,b} on/off per bar, left to right
  localparam logic [2:0] BarRgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                        3'b101, 3'b100, 3'b001, 3'b000};

  logic               last_vs_q;
  logic               sof;
  logic [2:0]         active_mode_q, active_mode_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic               dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               de_q;

  // One frame of box motion on one axis; returns {moving_negative, position}.
  function automatic logic [COORD_W:0] axis_step(input logic [COORD_W-1:0] pos,
                                                 input logic               neg,
                                                 input logic [COORD_W:0]   lim);
    logic [COORD_W:0] wide;
    wide = {1'b0, pos};
    if (!neg) begin
      wide = wide + SpeedW;
      if (wide >= lim) return {1'b1, lim[COORD_W-1:0]};
      return {1'b0, wide[COORD_W-1:0]};
    end
    if (wide <= SpeedW) return '0;
    wide = wide - SpeedW;
    return {1'b1, wide[COORD_W-1:0]};
  endfunction

  assign sof = ~last_vs_q & vs;

  always_comb begin
    active_mode_d = active_mode_q;
    frame_cnt_d   = frame_cnt_q;
    {dir_x_neg_d, box_x_d} = {dir_x_neg_q, box_x_q};
    {dir_y_neg_d, box_y_d} = {dir_y_neg_q, box_y_q};
    if (sof) begin
      active_mode_d = mode;
      frame_cnt_d   = frame_cnt_q + 8'd1;
      {dir_x_neg_d, box_x_d} = axis_step(box_x_q, dir_x_neg_q, LimX);
      {dir_y_neg_d, box_y_d} = axis_step(box_y_q, dir_y_neg_q, LimY);
    end
  end

  int unsigned x_w, y_w, bx_w, by_w;
  assign x_w  = 32'(pixelsX);
  assign y_w  = 32'(pixelsY);
  assign bx_w = 32'(box_x_q);
  assign by_w = 32'(box_y_q);

  logic mid_y, box0, blue0, green0, red0, box4;
  assign mid_y  = (y_w >= BORDER) && (y_w < V_ACTIVE - BORDER);
  assign box0   = (x_w + BOX_HALF >= HalfX) && (x_w <= HalfX + BOX_HALF) &&
                  (y_w + BOX_HALF >= HalfY) && (y_w <= HalfY + BOX_HALF);
  assign blue0  = !mid_y;
  assign green0 = mid_y && (x_w >= H_ACTIVE - BORDER);
  assign red0   = mid_y && (x_w < BORDER);
  assign box4   = (x_w >= bx_w) && (x_w < bx_w + BOX_SIZE) &&
                  (y_w >= by_w) && (y_w < by_w + BOX_SIZE);

  // Grey ramp takes the top COLOR_W bits of x, zero-padded when x is narrower
  logic [COLOR_W-1:0] grey;
  if (COORD_W >= COLOR_W) begin : g_grey_slice
    assign grey = pixelsX[COORD_W-1 -: COLOR_W];
  end else begin : g_grey_pad
    assign grey = {pixelsX, {(COLOR_W - COORD_W){1'b0}}};
  end

  logic [2:0] bar;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x_w >= k * BarW) bar = 3'(k);
    end
    if (de) begin
      case (active_mode_q)
        3'd0: begin
          if (box0)        {r_d, g_d, b_d} = {Full, Full, Full};
          else if (blue0)  b_d = Full;
          else if (green0) g_d = Full;
          else if (red0)   r_d = Full;
          else             {r_d, g_d, b_d} = {Dark, Dark, Dark};
        end
        3'd1: begin
          r_d = {COLOR_W{BarRgb[bar][2]}};
          g_d = {COLOR_W{BarRgb[bar][1]}};
          b_d = {COLOR_W{BarRgb[bar][0]}};
        end
        3'd2: begin
          if (pixelsX[CHECK_LOG2] ^ pixelsY[CHECK_LOG2]) {r_d, g_d, b_d} = {Full, Full, Full};
        end
        3'd3:    {r_d, g_d, b_d} = {grey, grey, grey};
        3'd4: begin
          if (box4) {r_d, g_d, b_d} = {Full, Full, Full};
          else      {r_d, g_d, b_d} = {Dark, Dark, Dark};
        end
        default: {r_d, g_d, b_d} = {Dark, Dark, Dark};
      endcase
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      last_vs_q     <= 1'b1;
      active_mode_q <= '0;
      frame_cnt_q   <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      dir_x_neg_q   <= 1'b0;
      dir_y_neg_q   <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      de_q          <= 1'b0;
    end else begin
      last_vs_q     <= vs;
      active_mode_q <= active_mode_d;
      frame_cnt_q   <= frame_cnt_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dir_x_neg_q   <= dir_x_neg_d;
      dir_y_neg_q   <= dir_y_neg_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      de_q          <= de;
    end
  end

  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign deOut      = de_q;
  assign frameCount = frame_cnt_q;
  assign activeMode = active_mode_q;

endmodule

// File: tb/tb_pattern_gen_multimode.sv
// Bench for pattern_gen_multimode: directed scenarios plus randomized traffic against a
// frame-level reference model.
module tb_pattern_gen_multimode;

  localparam int H = 800;
  localparam int V = 600;
  localparam int BoxSz = 64;
  localparam int Spd = 4;
  localparam logic [23:0] DarkRgb = 24'h202020;

  logic       clk;
  logic       reset;
  logic       vs;
  logic       de;
  logic [9:0] pixelsX;
  logic [9:0] pixelsY;
  logic [2:0] mode;
  logic [7:0] r, g, b;
  logic       deOut;
  logic [7:0] frameCount;
  logic [2:0] activeMode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_active, m_frame, m_bx, m_by, m_dx, m_dy;
  bit   m_lastvs;
  logic [23:0] exp_rgb;
  logic        exp_de;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  pattern_gen_multimode dut (
    .pixelClk   (clk),
    .reset      (reset),
    .vs         (vs),
    .de         (de),
    .pixelsX    (pixelsX),
    .pixelsY    (pixelsY),
    .mode       (mode),
    .r          (r),
    .g          (g),
    .b          (b),
    .deOut      (deOut),
    .frameCount (frameCount),
    .activeMode (activeMode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ref_rgb(int md, int x, int y, int bx, int by);
    int k;
    int gv;
    case (md)
      0: begin
        if (x - 400 <= 10 && 400 - x <= 10 && y - 300 <= 10 && 300 - y <= 10) return 24'hFFFFFF;
        if (y < 20 || y >= V - 20) return 24'h0000FF;
        if (x >= H - 20) return 24'h00FF00;
        if (x < 20) return 24'hFF0000;
        return DarkRgb;
      end
      1: begin
        k = x / (H / 8);
        if (k > 7) k = 7;
        return bar_tab[k];
      end
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      3: begin
        gv = (x / 4) % 256;
        return {gv[7:0], gv[7:0], gv[7:0]};
      end
      4: return (x >= bx && x < bx + BoxSz && y >= by && y < by + BoxSz) ? 24'hFFFFFF : DarkRgb;
      default: return DarkRgb;
    endcase
  endfunction

  // Advance one clock, predicting outputs from the inputs currently driven.
  task automatic step();
    exp_de  = de;
    exp_rgb = de ? ref_rgb(m_active, int'(pixelsX), int'(pixelsY), m_bx, m_by) : 24'h0;
    if (reset) begin
      exp_rgb  = 24'h0;
      exp_de   = 1'b0;
      m_active = 0;
      m_frame  = 0;
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    end else if (!m_lastvs && vs) begin
      m_active = int'(mode);
      m_frame  = (m_frame + 1) % 256;
      m_bx = m_bx + m_dx * Spd;
      if (m_bx >= H - BoxSz) begin m_bx = H - BoxSz; m_dx = -1; end
      else if (m_bx <= 0) begin m_bx = 0; m_dx = 1; end
      m_by = m_by + m_dy * Spd;
      if (m_by >= V - BoxSz) begin m_by = V - BoxSz; m_dy = -1; end
      else if (m_by <= 0) begin m_by = 0; m_dy = 1; end
    end
    m_lastvs = reset ? 1'b1 : vs;
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse(input int md);
    mode = 3'(md);
    de   = 1'b0;
    vs   = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vs    = 1'b0;
    de    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vs = 1'b1; de = 1'b1; mode = 3'd3;
    pixelsX = 10'd400; pixelsY = 10'd300;
    step();
    step();
    checks++;
    if ({r, g, b} !== 24'h0 || deOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: rgb=%h deOut=%b, required 000000/0", {r, g, b}, deOut);
    end
    checks++;
    if (frameCount !== 8'd0 || activeMode !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: frameCount=%0d activeMode=%0d, required 0/0", frameCount,
               activeMode);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (frameCount !== 8'd0) begin
      errors++;
      $display("FAIL vs_high_no_sof: frameCount=%0d, required 0", frameCount);
    end
  endtask

  task automatic test_border();
    int tx [5] = '{400, 5, 790, 5, 200};
    int ty [5] = '{300, 100, 100, 5, 200};
    logic [23:0] te [5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h202020};
    de = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixelsX = 10'(tx[i]); pixelsY = 10'(ty[i]);
      step();
      checks++;
      if ({r, g, b} !== te[i] || deOut !== 1'b1) begin
        errors++;
        $display("FAIL border(%0d,%0d): rgb=%h deOut=%b, required %h/1", tx[i], ty[i],
                 {r, g, b}, deOut, te[i]);
      end
    end
  endtask

  task automatic test_bars();
    int tx [5] = '{0, 99, 100, 700, 799};
    logic [23:0] te [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};
    sof_pulse(1);
    de = 1'b1;
    pixelsY = 10'd10;
    for (int i = 0; i < 5; i++) begin
      pixelsX = 10'(tx[i]);
      step();
      checks++;
      if ({r, g, b} !== te[i]) begin
        errors++;
        $display("FAIL bars x=%0d: rgb=%h, required %h", tx[i], {r, g, b}, te[i]);
      end
    end
    de = 1'b0;
    step();
    checks++;
    if ({r, g, b} !== 24'h0 || deOut !== 1'b0) begin
      errors++;
      $display("FAIL de_low: rgb=%h deOut=%b, required 000000/0", {r, g, b}, deOut);
    end
  endtask

  task automatic test_checker_grey();
    int tx [5] = '{0, 32, 32, 512, 4};
    int ty [5] = '{0, 0, 32, 7, 7};
    logic [23:0] te [5] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h808080, 24'h010101};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) sof_pulse(2);
      if (i == 3) sof_pulse(3);
      de = 1'b1;
      pixelsX = 10'(tx[i]); pixelsY = 10'(ty[i]);
      step();
      checks++;
      if ({r, g, b} !== te[i]) begin
        errors++;
        $display("FAIL checker_grey(%0d,%0d): rgb=%h, required %h", tx[i], ty[i], {r, g, b},
                 te[i]);
      end
    end
  endtask

  task automatic test_box();
    logic [23:0] got_in, got_out;
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      sof_pulse(4);
      de = 1'b1;
      pixelsY = 10'(m_by);
      pixelsX = 10'(m_bx);
      step();
      got_in = {r, g, b};
      pixelsX = 10'(m_bx + BoxSz);
      step();
      got_out = {r, g, b};
      checks++;
      if (got_in !== 24'hFFFFFF || got_out !== DarkRgb) begin
        errors++;
        $display("FAIL box sof=%0d bx=%0d by=%0d: in=%h out=%h, required FFFFFF/202020", n,
                 m_bx, m_by, got_in, got_out);
      end
      if (n == 184 || n == 185) begin
        pixelsX = (n == 184) ? 10'd736 : 10'd732;
        step();
        got_in = {r, g, b};
        pixelsX = (n == 184) ? 10'd735 : 10'd731;
        step();
        got_out = {r, g, b};
        checks++;
        if (got_in !== 24'hFFFFFF || got_out !== DarkRgb) begin
          errors++;
          $display("FAIL box_edge sof=%0d: in=%h out=%h, required FFFFFF/202020", n, got_in,
                   got_out);
        end
      end
    end
    checks++;
    if (frameCount !== 8'd200) begin
      errors++;
      $display("FAIL box_frames: frameCount=%0d, required 200", frameCount);
    end
  endtask

  task automatic test_mode_switch();
    logic [23:0] seen [4];
    logic [2:0]  am [4];
    sof_pulse(0);
    de = 1'b1; pixelsX = 10'd32; pixelsY = 10'd0;
    mode = 3'd2;
    step();                 seen[0] = {r, g, b}; am[0] = activeMode;
    vs = 1'b0; step();      seen[1] = {r, g, b}; am[1] = activeMode;
    vs = 1'b1; step();      seen[2] = {r, g, b}; am[2] = activeMode;
    step();                 seen[3] = {r, g, b}; am[3] = activeMode;
    checks++;
    if (seen[0] !== 24'h0000FF || seen[1] !== 24'h0000FF || seen[2] !== 24'h0000FF ||
        seen[3] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL mode_switch_rgb: %h %h %h %h, required 0000ff 0000ff 0000ff ffffff",
               seen[0], seen[1], seen[2], seen[3]);
    end
    checks++;
    if (am[0] !== 3'd0 || am[1] !== 3'd0 || am[2] !== 3'd2 || am[3] !== 3'd2) begin
      errors++;
      $display("FAIL mode_switch_active: %0d %0d %0d %0d, required 0 0 2 2", am[0], am[1],
               am[2], am[3]);
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) sof_pulse(i % 8);
    checks++;
    if (frameCount !== 8'd255) begin
      errors++;
      $display("FAIL frame_255: frameCount=%0d, required 255", frameCount);
    end
    sof_pulse(6);
    checks++;
    if (frameCount !== 8'd0 || activeMode !== 3'd6) begin
      errors++;
      $display("FAIL frame_wrap: frameCount=%0d activeMode=%0d, required 0/6", frameCount,
               activeMode);
    end
  endtask

  task automatic test_reset_sof();
    sof_pulse(3);
    sof_pulse(3);
    vs = 1'b0; step();
    vs = 1'b1; reset = 1'b1; de = 1'b1;
    step();
    checks++;
    if (frameCount !== 8'd0 || activeMode !== 3'd0 || {r, g, b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_sof: frameCount=%0d activeMode=%0d rgb=%h, required 0/0/000000",
               frameCount, activeMode, {r, g, b});
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    sof_pulse(5);
    checks++;
    if (frameCount !== 8'd1 || activeMode !== 3'd5) begin
      errors++;
      $display("FAIL after_reset_sof: frameCount=%0d activeMode=%0d, required 1/5", frameCount,
               activeMode);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
      de = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) begin
        pixelsX = 10'($urandom_range(0, 1023));
        pixelsY = 10'($urandom_range(0, 1023));
      end else begin
        pixelsX = 10'(m_bx + $urandom_range(0, 70) - 3 + ((m_bx < 3) ? 3 : 0));
        pixelsY = 10'(m_by + $urandom_range(0, 70) - 3 + ((m_by < 3) ? 3 : 0));
      end
      step();
      checks++;
      if ({r, g, b} !== exp_rgb || deOut !== exp_de || frameCount !== 8'(m_frame) ||
          activeMode !== 3'(m_active)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc=%0d: rgb=%h de=%b fc=%0d am=%0d, required %h/%b/%0d/%0d",
                   i, {r, g, b}, deOut, frameCount, activeMode, exp_rgb, exp_de, m_frame,
                   m_active);
      end
    end
  endtask

  initial begin
    reset = 1'b1; vs = 1'b0; de = 1'b0; mode = 3'd0;
    pixelsX = '0; pixelsY = '0;
    test_reset();
    test_border();
    test_bars();
    test_checker_grey();
    test_mode_switch();
    test_box();
    test_frame_wrap();
    test_reset_sof();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
